// File: rtl/cla_pipe_clk_pkg.sv
// Shared defaults and helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pipe_clk_pkg;

  localparam int CLA_WIDTH_DFLT  = 32;
  localparam int CLA_STAGES_DFLT = 4;

  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? width / stages : 0;
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// Combinational W-bit carry-lookahead adder chunk; every carry is a flat
// generate/propagate sum-of-products rather than a ripple chain.
module cla_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  always_comb begin
    logic t;
    logic pp;
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      t  = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        t  = t | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = t | (pp & ci);
    end
  end

  assign s     = p ^ c[W-1:0];
  assign co    = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/cla_pipe_clk.sv
// Pipelined WIDTH-bit adder/subtractor: an entry register plus STAGES
// carry-lookahead chunk stages with the inter-chunk carry registered.
module cla_pipe_clk
  import cla_pipe_clk_pkg::*;
#(
  parameter int WIDTH  = CLA_WIDTH_DFLT,
  parameter int STAGES = CLA_STAGES_DFLT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if ((STAGES < 1) || (CW < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_chk
    $error("cla_pipe_clk: WIDTH must be a positive multiple of STAGES");
  end

  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  // Stage k register holds: finished sum chunks below k*CW and raw operand A
  // above it (aw), the not-yet-used part of b_eff (bw), the chunk carry-in and valid.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int RB = WIDTH - k * CW;

    logic [WIDTH-1:0] aw_q, aw_d;
    logic [RB-1:0]    bw_q, bw_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic [CW-1:0]    ch_s;
    logic             ch_co;
    logic             ch_cmsb;

    cla_chunk #(.W(CW)) u_chunk (
      .a    (aw_q[k*CW +: CW]),
      .b    (bw_q[CW-1:0]),
      .ci   (c_q),
      .s    (ch_s),
      .co   (ch_co),
      .c_msb(ch_cmsb)
    );

    if (k == 0) begin : g_load
      always_comb begin
        aw_d = a;
        bw_d = sub ? ~b : b;
        c_d  = sub | ci;
        v_d  = in_valid;
      end
    end else begin : g_load
      always_comb begin
        aw_d                  = g_stg[k-1].aw_q;
        aw_d[(k-1)*CW +: CW]  = g_stg[k-1].ch_s;
        bw_d                  = g_stg[k-1].bw_q[WIDTH-(k-1)*CW-1:CW];
        c_d                   = g_stg[k-1].ch_co;
        v_d                   = g_stg[k-1].v_q;
      end
    end

    if (k != STAGES - 1) begin : g_mid
      logic unused_c_msb;
      assign unused_c_msb = ch_cmsb;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        aw_q <= '0;
        bw_q <= '0;
        c_q  <= 1'b0;
        v_q  <= 1'b0;
      end else if (en) begin
        aw_q <= aw_d;
        bw_q <= bw_d;
        c_q  <= c_d;
        v_q  <= v_d;
      end
    end
  end

  always_comb begin
    s_d                        = g_stg[STAGES-1].aw_q;
    s_d[(STAGES-1)*CW +: CW]   = g_stg[STAGES-1].ch_s;
    co_d                       = g_stg[STAGES-1].ch_co;
    ovf_d                      = g_stg[STAGES-1].ch_co ^ g_stg[STAGES-1].ch_cmsb;
    out_valid_d                = g_stg[STAGES-1].v_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      s_q         <= s_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign co        = co_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cla_pipe_clk.sv
// Scoreboard bench for cla_pipe_clk: arithmetic reference model, random and
// directed stimulus, stall/bubble/reset scenarios.
module tb_cla_pipe_clk;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             ci = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  cla_pipe_clk #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .ci       (ci),
    .sub      (sub),
    .out_valid(out_valid),
    .s        (s),
    .co       (co),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    int          adv;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   adv = 0;
  bit   en_last = 1'b0;
  bit   have_prev = 1'b0;
  logic [34:0] prev_out;

  function automatic exp_t model(logic [31:0] aa, logic [31:0] bb, logic cc, logic ss);
    exp_t m;
    longint unsigned full;
    longint sa, sbv, r;
    sa  = longint'($signed(aa));
    sbv = longint'($signed(bb));
    if (ss) begin
      m.s  = aa - bb;
      m.co = (aa >= bb);
      r    = sa - sbv;
    end else begin
      full = longint'(aa) + longint'(bb) + (cc ? 64'd1 : 64'd0);
      m.s  = full[31:0];
      m.co = full[32];
      r    = sa + sbv + (cc ? 64'sd1 : 64'sd0);
    end
    m.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    m.adv = 0;
    return m;
  endfunction

  // Stimulus side: record the expected response for every accepted operand.
  always @(posedge clk) begin : push_blk
    exp_t e;
    en_last = en;
    if (reset_n && en) begin
      adv++;
      if (in_valid) begin
        e = model(a, b, ci, sub);
        e.adv = adv;
        sb.push_back(e);
      end
    end
  end

  // Monitor: pops one expectation per freshly loaded valid output.
  always @(negedge clk) begin : mon_blk
    exp_t e;
    if (reset_n) begin
      if (!en_last && have_prev) begin
        n_vec++;
        if ({out_valid, co, ovf, s} !== prev_out) begin
          n_err++;
          $display("FAIL stall_hold: got %h want %h", {out_valid, co, ovf, s}, prev_out);
        end
      end else if (out_valid) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid: got s=%h with no pending operation, want out_valid=0", s);
        end else begin
          e = sb.pop_front();
          if (s !== e.s || co !== e.co || ovf !== e.ovf || (adv - e.adv) != STAGES) begin
            n_err++;
            $display("FAIL result: got s=%h co=%b ovf=%b lat=%0d want s=%h co=%b ovf=%b lat=%0d",
                     s, co, ovf, adv - e.adv, e.s, e.co, e.ovf, STAGES);
          end
        end
      end
      prev_out  = {out_valid, co, ovf, s};
      have_prev = 1'b1;
    end else begin
      have_prev = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                       input logic cc, input logic ss);
    in_valid = v;
    a   = aa;
    b   = bb;
    ci  = cc;
    sub = ss;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, $urandom, $urandom, 1'b0, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_s"}, s, 32'd0);
    chk({tag, "_co"}, {31'd0, co}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  logic [31:0] edge_vals [4];

  initial begin
    edge_vals[0] = 32'hFFFF_FFFF;
    edge_vals[1] = 32'h7FFF_FFFF;
    edge_vals[2] = 32'h8000_0000;
    edge_vals[3] = 32'h0000_0000;

    // Reset held with operands offered
    reset_n  = 1'b0;
    en       = 1'b1;
    in_valid = 1'b1;
    a        = 32'h1234_5678;
    b        = 32'h0FED_CBA9;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset_n = 1'b1;
    in_valid = 1'b0;
    idle(2);

    // Directed add stream, back to back
    issue(1'b1, 32'h0001_000F, 32'h0000_0001, 1'b0, 1'b0);
    issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    issue(1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0);
    issue(1'b1, 32'h0814_D1A0, 32'h1220_7E0A, 1'b0, 1'b0);
    // Subtract, including overflow and ignored ci
    issue(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue(1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1);
    issue(1'b1, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1);
    issue(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    idle(6);

    // Stall mid-stream while a valid result sits on the outputs
    issue(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    issue(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    issue(1'b1, 32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 1'b0);
    issue(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
    issue(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    en = 1'b0;
    issue(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
    issue(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
    issue(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
    en = 1'b1;
    idle(8);

    // Bubble pattern 1,0,1
    issue(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(1'b1, 32'h0000_1000, 32'h0000_0001, 1'b0, 1'b1);
    idle(6);

    // Randomised mix of adds, subtracts, bubbles and stalls
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 5) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 5) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      en = ($urandom_range(0, 7) != 0);
      issue(($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    en = 1'b1;
    idle(8);

    // Asynchronous reset with operations in flight and a valid result showing
    for (int i = 0; i < 6; i++) issue(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check_zero_outputs("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(10);
    issue(1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1);
    idle(2);

    // Bounded drain of outstanding expectations
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_pending", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
